hello_rom_loader: RTL

- Boot-image loader sitting directly upstream of the on-chip program memory, driving that memory's s1 Avalon slave port (chipselect/write/debugaccess/byteenable/address/writedata/readdata/clken).
- Accepts a byte stream over a valid/ready interface, typically a JTAG/UART receive FIFO.
- Packs bytes little-endian into 32-bit words, writes each word with debugaccess asserted, reads it back to verify, and keeps a running checksum.
- Holds the CPU in reset while loading.

---
 rtl/hello_rom_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hello_rom_loader.sv
// Boot loader: packs a byte stream little-endian into 32-bit words, writes each with debugaccess, reads back to verify.
// 7 cycles per word minimum (4 bytes + WRITE + READ + CHECK); in_ready is low outside COLLECT so the stream stalls.
module hello_rom_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2560
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rom_address,
  output logic [3:0]        rom_byteenable,
  output logic              rom_chipselect,
  output logic              rom_write,
  output logic              rom_debugaccess,
  output logic [31:0]       rom_writedata,
  output logic              rom_clken,
  input  logic [31:0]       rom_readdata,
  output logic              cpu_reset_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, WRITE, READ, CHECK, DONE, ERROR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [31:0]       word_buf;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] wc;

  // Full-word writes only; the memory clock is never gated.
  assign rom_byteenable = 4'hF;
  assign rom_clken      = 1'b1;
  assign rom_address    = idx;
  assign rom_writedata  = word_buf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      word_buf        <= '0;
      byte_cnt        <= '0;
      idx             <= '0;
      wc              <= '0;
      in_ready        <= 1'b0;
      rom_chipselect  <= 1'b0;
      rom_write       <= 1'b0;
      rom_debugaccess <= 1'b0;
      cpu_reset_req   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_addr        <= '0;
      checksum        <= '0;
    end else if (abort) begin
      state           <= IDLE;
      byte_cnt        <= '0;
      in_ready        <= 1'b0;
      rom_chipselect  <= 1'b0;
      rom_write       <= 1'b0;
      rom_debugaccess <= 1'b0;
      cpu_reset_req   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            checksum <= '0;
            err_addr <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            idx      <= '0;
            byte_cnt <= '0;
            wc       <= word_count;
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if ({1'b0, word_count} > DEPTH_LIM) begin
              state    <= ERROR;
              error    <= 1'b1;
              err_addr <= word_count;
            end else begin
              state         <= COLLECT;
              in_ready      <= 1'b1;
              cpu_reset_req <= 1'b1;
              busy          <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (in_valid && in_ready) begin
            word_buf <= {in_data, word_buf[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state           <= WRITE;
              in_ready        <= 1'b0;
              rom_chipselect  <= 1'b1;
              rom_write       <= 1'b1;
              rom_debugaccess <= 1'b1;
            end
          end
        end
        WRITE: begin
          checksum        <= checksum + word_buf;
          rom_write       <= 1'b0;
          rom_debugaccess <= 1'b0;
          state           <= READ;
        end
        READ: begin
          rom_chipselect <= 1'b0;
          state          <= CHECK;
        end
        CHECK: begin
          if (rom_readdata != word_buf) begin
            state         <= ERROR;
            error         <= 1'b1;
            err_addr      <= idx;
            cpu_reset_req <= 1'b0;
            busy          <= 1'b0;
          end else if (idx == wc - ADDR_W'(1)) begin
            state         <= DONE;
            done          <= 1'b1;
            cpu_reset_req <= 1'b0;
            busy          <= 1'b0;
          end else begin
            idx      <= idx + ADDR_W'(1);
            in_ready <= 1'b1;
            state    <= COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
